gen_crd_rtn_top: RTL

// - Receiver end of the credit-based link driven by the generic credit manager.
// - Buffers words pushed by a credit-holding sender in a DEPTH-entry FIFO and drains them to a local consumer over valid/ready.
// - Returns one credit per drained entry to the sender on crd_grnt_val/crd_grnt_en, coalescing returns into batches of up to MAX_CRD_GRNT_VAL.
// - Sender must be configured with CRD_INIT_AMOUNT=DEPTH and a matching MAX_CRD_GRNT_VAL.

---
 rtl/gen_crd_rtn_top.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gen_crd_rtn_top.sv
// rtl/gen_crd_rtn_top.sv - credit-return receiver: DEPTH-entry FIFO with coalesced credit grants
// Optional feature macro: GEN_CRD_RTN_COALESCE_EN (batching + timeout); default build returns one credit per pop.
module gen_crd_rtn_top #(
    parameter int DAT_W            = 8,
    parameter int DEPTH            = 8,
    parameter int MAX_CRD_GRNT_VAL = 2,
    parameter int RTN_TIMEOUT      = 4,
    localparam int CNT_W           = $clog2(DEPTH) + 1,
    localparam int CRD_GRNT_W      = $clog2(MAX_CRD_GRNT_VAL) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [DAT_W-1:0]      in_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DAT_W-1:0]      out_dat,
    output logic [CRD_GRNT_W-1:0] crd_grnt_val,
    output logic                  crd_grnt_en,
    output logic [CNT_W-1:0]      fill_cnt,
    output logic                  ovf_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // An out-of-range configuration elaborates this marker block; the sender
    // and receiver would disagree on batch sizes otherwise.
    if (MAX_CRD_GRNT_VAL < 1 || MAX_CRD_GRNT_VAL > DEPTH || RTN_TIMEOUT < 1) begin : g_illegal_config
    end

    logic [DAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is dropped even if a pop frees a slot this
    // cycle: the freed credit has not reached the sender yet.
    assign full    = (fill_cnt == FULL_CNT);
    assign push    = in_vld && !full;
    assign out_vld = (fill_cnt != '0);
    assign pop     = out_vld && out_rdy;
    assign out_dat = mem[rd_ptr];

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fill_cnt <= fill_cnt + CNT_W'(1);
                2'b01:   fill_cnt <= fill_cnt - CNT_W'(1);
                default: fill_cnt <= fill_cnt;
            endcase
            if (in_vld && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

`ifdef GEN_CRD_RTN_COALESCE_EN

    localparam int TMR_W = $clog2(RTN_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RTN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CRD_GRNT_VAL);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TMR_W-1:0]        timer;
    logic [TMR_W-1:0]        timer_nxt;
    logic [CNT_W-1:0]        pend;
    logic [CNT_W-1:0]        pend_nxt;
    logic [CNT_W-1:0]        rtn;
    logic                    en_nxt;
    logic [CRD_GRNT_W-1:0]   val_nxt;

    // Next credit-return state. The grant outputs are registered copies of
    // the grant decode applied to next pend/timer, so they always equal the
    // decode of the current registered pend/timer and have no input path.
    always_comb begin
        rtn       = crd_grnt_en ? CNT_W'(crd_grnt_val) : '0;
        pend_nxt  = pend + CNT_W'(pop) - rtn;
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (pop) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (crd_grnt_en) begin
                    timer_nxt = '0;
                    state_nxt = (pend_nxt != '0) ? ACCUM : IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
        endcase
        en_nxt  = (state_nxt == ACCUM) && ((pend_nxt >= MAX_CNT) || (timer_nxt == TMR_LAST));
        val_nxt = '0;
        if (en_nxt) begin
            val_nxt = (pend_nxt >= MAX_CNT) ? CRD_GRNT_W'(MAX_CRD_GRNT_VAL) : CRD_GRNT_W'(pend_nxt);
        end
    end

    // Return FSM with registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            pend         <= '0;
            crd_grnt_en  <= 1'b0;
            crd_grnt_val <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            pend         <= pend_nxt;
            crd_grnt_en  <= en_nxt;
            crd_grnt_val <= val_nxt;
        end
    end

`else

    logic [CNT_W-1:0]      pend;
    logic [CNT_W-1:0]      pend_nxt;
    logic                  en_nxt;
    logic [CRD_GRNT_W-1:0] val_nxt;

    // Without batching every unreturned credit goes back the cycle after its
    // pop, so pend never exceeds one.
    always_comb begin
        pend_nxt = pend + CNT_W'(pop) - CNT_W'(crd_grnt_en);
        en_nxt   = (pend_nxt != '0);
        val_nxt  = en_nxt ? CRD_GRNT_W'(1) : '0;
    end

    // Registered single-credit return strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            crd_grnt_en  <= 1'b0;
            crd_grnt_val <= '0;
        end else begin
            pend         <= pend_nxt;
            crd_grnt_en  <= en_nxt;
            crd_grnt_val <= val_nxt;
        end
    end

`endif

endmodule
